hack_cpu_control: RTL and testbench

- Multi-cycle sequencer for the Hack CPU, and the producer of the ALU's six control bits (zx,nx,zy,ny,f,no).
- Fetches a 16-bit instruction over a ROM handshake and decodes it.
- Drives the external combinational ALU with operands and control bits, then consumes its out/zr/ng.
- Owns A, D and PC; performs data-RAM reads/writes over req/ack handshakes; evaluates jumps.

---
 rtl/hack_pkg.sv | 49 ++++
 rtl/hack_jump_unit.sv | 19 +
 rtl/hack_cpu_control.sv | 155 +++++++++++++++
 tb/tb_hack_cpu_control.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg
// Shared definitions for the Hack CPU control slice. It holds the sequencer
// state encoding, the bit offsets of the instruction fields, the six-bit ALU
// control codes and the default data/address widths.
package hack_pkg;

    // Default widths: 16-bit words, 15-bit ROM/RAM addresses.
    localparam int W_DEF    = 16;
    localparam int PC_W_DEF = 15;

    // Instruction field offsets within a C-instruction.
    localparam int A_BIT = 12;  // selects M (1) or A (0) as the ALU y operand
    localparam int C_MSB = 11;  // comp field {zx,nx,zy,ny,f,no} = IR[11:6]
    localparam int C_LSB = 6;
    localparam int D_MSB = 5;   // dest field {d1,d2,d3} = IR[5:3]
    localparam int J_MSB = 2;   // jump field {j1,j2,j3} = IR[2:0]

    // The ALU's defined control codes, {zx,nx,zy,ny,f,no}. "A" and "Y" mean
    // the y operand, which is A or M depending on the a bit.
    localparam logic [5:0] ALU_ZERO    = 6'b101010;
    localparam logic [5:0] ALU_ONE     = 6'b111111;
    localparam logic [5:0] ALU_NEG1    = 6'b111010;
    localparam logic [5:0] ALU_D       = 6'b001100;
    localparam logic [5:0] ALU_A       = 6'b110000;
    localparam logic [5:0] ALU_NOTD    = 6'b001101;
    localparam logic [5:0] ALU_NOTA    = 6'b110001;
    localparam logic [5:0] ALU_NEGD    = 6'b001111;
    localparam logic [5:0] ALU_NEGA    = 6'b110011;
    localparam logic [5:0] ALU_DPLUS1  = 6'b011111;
    localparam logic [5:0] ALU_APLUS1  = 6'b110111;
    localparam logic [5:0] ALU_DMINUS1 = 6'b001110;
    localparam logic [5:0] ALU_AMINUS1 = 6'b110010;
    localparam logic [5:0] ALU_DPLUSY  = 6'b000010;
    localparam logic [5:0] ALU_DMINUSY = 6'b010011;
    localparam logic [5:0] ALU_YMINUSD = 6'b000111;
    localparam logic [5:0] ALU_DANDY   = 6'b000000;
    localparam logic [5:0] ALU_DORY    = 6'b010101;

    // Sequencer states of the multi-cycle core.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4,
        COMMIT = 3'd5
    } state_t;

endpackage

// File: rtl/hack_jump_unit.sv
// hack_jump_unit
// Combinational jump-condition evaluator. It is kept separate so that a later
// pipelined core can reuse it unchanged.
// Ports:
//   j    in  3  jump field {j1,j2,j3}: jump if <0, ==0, >0
//   zr   in  1  result was zero
//   ng   in  1  result was negative
//   take out 1  jump is taken
module hack_jump_unit (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    // "Positive" is neither zero nor negative.
    assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_control.sv
// hack_cpu_control
// Multi-cycle sequencer for the Hack CPU. It fetches an instruction over a ROM
// handshake and decodes it. It drives the external combinational ALU and
// latches the ALU result. It performs data-RAM reads and writes, updates A, D
// and PC, and evaluates jumps.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   rom_req/rom_addr           fetch request, address = PC
//   rom_valid/rom_data         fetch response
//   ram_addr                   data address = A[PC_W-1:0]
//   ram_rd/ram_rvalid/rdata    read request and response
//   ram_wr/ram_wdata/ram_wack  write request, data and acceptance
//   alu_x/alu_y/alu_ctl        ALU operands (D, A or M) and {zx,nx,zy,ny,f,no}
//   alu_out/alu_zr/alu_ng      ALU result and flags
//   pc/a_reg/d_reg             architectural state
//   instr_done                 one-cycle pulse in the cycle an instruction commits
module hack_cpu_control
    import hack_pkg::*;
#(
    parameter int              W        = W_DEF,
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic            rom_valid,
    input  logic [W-1:0]    rom_data,
    output logic [PC_W-1:0] ram_addr,
    output logic            ram_rd,
    input  logic            ram_rvalid,
    input  logic [W-1:0]    ram_rdata,
    output logic            ram_wr,
    output logic [W-1:0]    ram_wdata,
    input  logic            ram_wack,
    output logic [W-1:0]    alu_x,
    output logic [W-1:0]    alu_y,
    output logic [5:0]      alu_ctl,
    input  logic [W-1:0]    alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] pc,
    output logic [W-1:0]    a_reg,
    output logic [W-1:0]    d_reg,
    output logic            instr_done
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [W-1:0]    a_q, d_q, ir_q, mbuf_q, r_q;
    logic            zr_q, ng_q;
    logic            take;
    logic            is_c;

    assign is_c = ir_q[W-1];

    hack_jump_unit u_jump (
        .j    (ir_q[J_MSB:J_MSB-2]),
        .zr   (zr_q),
        .ng   (ng_q),
        .take (take)
    );

    // State register. Reset overrides any handshake that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic. Each wait state is held until its response arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (rom_valid) state_d = DECODE;
            DECODE: begin
                if (!is_c)            state_d = FETCH;
                else if (ir_q[A_BIT]) state_d = MREAD;
                else                  state_d = EXEC;
            end
            MREAD:   if (ram_rvalid) state_d = EXEC;
            EXEC:    state_d = ir_q[D_MSB-2] ? MWRITE : COMMIT;
            MWRITE:  if (ram_wack) state_d = COMMIT;
            COMMIT:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Output decode. Requests follow the state directly, so each request
    // drops in the cycle after its response is sampled.
    always_comb begin
        rom_req    = 1'b0;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH:   rom_req    = 1'b1;
            DECODE:  instr_done = !is_c;
            MREAD:   ram_rd     = 1'b1;
            MWRITE:  ram_wr     = 1'b1;
            COMMIT:  instr_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers. In COMMIT, PC and the destinations use the old A,
    // so an instruction of the form A=...;JMP jumps to the A it started with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            a_q    <= '0;
            d_q    <= '0;
            ir_q   <= '0;
            mbuf_q <= '0;
            r_q    <= '0;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH:  if (rom_valid) ir_q <= rom_data;
                DECODE: begin
                    if (!is_c) begin
                        a_q  <= {{(W-PC_W){1'b0}}, ir_q[PC_W-1:0]};
                        pc_q <= pc_q + PC_ONE;
                    end
                end
                MREAD:  if (ram_rvalid) mbuf_q <= ram_rdata;
                EXEC: begin
                    r_q  <= alu_out;
                    zr_q <= alu_zr;
                    ng_q <= alu_ng;
                end
                COMMIT: begin
                    if (ir_q[D_MSB])   a_q <= r_q;
                    if (ir_q[D_MSB-1]) d_q <= r_q;
                    pc_q <= take ? a_q[PC_W-1:0] : pc_q + PC_ONE;
                end
                default: ;
            endcase
        end
    end

    assign rom_addr  = pc_q;
    assign ram_addr  = a_q[PC_W-1:0];
    assign ram_wdata = r_q;
    assign alu_x     = d_q;
    assign alu_y     = ir_q[A_BIT] ? mbuf_q : a_q;
    assign alu_ctl   = ir_q[C_MSB:C_LSB];
    assign pc        = pc_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;

endmodule

// File: tb/tb_hack_cpu_control.sv
// tb_hack_cpu_control
// Testbench for hack_cpu_control. It provides the ROM and RAM responders with
// configurable wait states and a bit-level external ALU. An instruction-level
// model of Hack semantics predicts A, D, PC, memory traffic and latency.
module tb_hack_cpu_control;
    import hack_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rom_req, rom_valid;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [14:0] ram_addr;
    logic        ram_rd, ram_rvalid, ram_wr, ram_wack;
    logic [15:0] ram_rdata, ram_wdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctl;
    logic        alu_zr, alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;
    logic        instr_done;

    int check_count = 0;
    int err_count   = 0;

    logic [15:0] mem [0:32767];
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;

    int          last_lat, last_rd_cyc, last_wr_cyc;
    logic [15:0] last_alu_y, last_wr_data;
    logic [5:0]  last_alu_ctl;
    logic [14:0] last_wr_addr;

    logic [5:0] codes [18] = '{ALU_ZERO, ALU_ONE, ALU_NEG1, ALU_D, ALU_A,
                               ALU_NOTD, ALU_NOTA, ALU_NEGD, ALU_NEGA,
                               ALU_DPLUS1, ALU_APLUS1, ALU_DMINUS1, ALU_AMINUS1,
                               ALU_DPLUSY, ALU_DMINUSY, ALU_YMINUSD,
                               ALU_DANDY, ALU_DORY};

    hack_cpu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_valid  (rom_valid),
        .rom_data   (rom_data),
        .ram_addr   (ram_addr),
        .ram_rd     (ram_rd),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata),
        .ram_wr     (ram_wr),
        .ram_wdata  (ram_wdata),
        .ram_wack   (ram_wack),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctl    (alu_ctl),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .pc         (pc),
        .a_reg      (a_reg),
        .d_reg      (d_reg),
        .instr_done (instr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External Hack ALU, implemented bit-wise from the control flags.
    logic [15:0] bx, by, bo;
    always_comb begin
        bx = alu_x;
        if (alu_ctl[5]) bx = '0;
        if (alu_ctl[4]) bx = ~bx;
        by = alu_y;
        if (alu_ctl[3]) by = '0;
        if (alu_ctl[2]) by = ~by;
        bo = alu_ctl[1] ? bx + by : bx & by;
        if (alu_ctl[0]) bo = ~bo;
    end
    assign alu_out = bo;
    assign alu_zr  = (bo == 16'd0);
    assign alu_ng  = bo[15];

    // Reference semantics of each comp mnemonic, written as plain arithmetic.
    function automatic logic [15:0] comp_val(input logic [5:0] c, input logic [15:0] dv,
                                             input logic [15:0] yv);
        case (c)
            ALU_ZERO:    return 16'd0;
            ALU_ONE:     return 16'd1;
            ALU_NEG1:    return 16'hFFFF;
            ALU_D:       return dv;
            ALU_A:       return yv;
            ALU_NOTD:    return ~dv;
            ALU_NOTA:    return ~yv;
            ALU_NEGD:    return -dv;
            ALU_NEGA:    return -yv;
            ALU_DPLUS1:  return dv + 16'd1;
            ALU_APLUS1:  return yv + 16'd1;
            ALU_DMINUS1: return dv - 16'd1;
            ALU_AMINUS1: return yv - 16'd1;
            ALU_DPLUSY:  return dv + yv;
            ALU_DMINUSY: return dv - yv;
            ALU_YMINUSD: return yv - dv;
            ALU_DANDY:   return dv & yv;
            ALU_DORY:    return dv | yv;
            default:     return 16'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n      = 1'b0;
        rom_valid  = 1'b0;
        ram_rvalid = 1'b0;
        ram_wack   = 1'b0;
        @(posedge clk);
        #1;
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_a", 32'(a_reg), 32'd0);
        checkOutput("rst_d", 32'(d_reg), 32'd0);
        checkOutput("rst_rom_req", 32'(rom_req), 32'd1);
        checkOutput("rst_ram_rd", 32'(ram_rd), 32'd0);
        checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
        checkOutput("rst_done", 32'(instr_done), 32'd0);
        rst_n = 1'b1;
    endtask

    // Runs one instruction to commit, with the given ROM/read/write wait
    // states, and checks it against the instruction-level model.
    task automatic applyStimulus(input logic [15:0] instr, input int romw, input int rdw,
                                 input int wrw);
        logic [15:0] a_old, d_old, y_val, v;
        logic        is_c, use_m, wr_m, take;
        int          exp_lat, cyc, rom_cyc, rd_cyc, wr_cyc, quiet;
        bit          done;
        a_old   = m_a;
        d_old   = m_d;
        is_c    = instr[15];
        use_m   = is_c && instr[12];
        wr_m    = is_c && instr[3];
        y_val   = use_m ? mem[a_old[14:0]] : a_old;
        v       = comp_val(instr[11:6], d_old, y_val);
        take    = is_c && ((instr[2] && $signed(v) < 0) || (instr[1] && v == 16'd0) ||
                           (instr[0] && $signed(v) > 0));
        exp_lat = is_c ? romw + 4 + (use_m ? rdw + 1 : 0) + (wr_m ? wrw + 1 : 0) : romw + 2;
        cyc = 0; rom_cyc = 0; rd_cyc = 0; wr_cyc = 0; quiet = 0; done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            cyc++;
            rom_valid  = 1'b0;
            ram_rvalid = 1'b0;
            ram_wack   = 1'b0;
            if (rom_req) begin
                rom_cyc++;
                if (rom_cyc == romw + 1) begin
                    checkOutput("rom_addr", 32'(rom_addr), 32'(m_pc));
                    rom_valid = 1'b1;
                    rom_data  = instr;
                end
            end
            if (ram_rd) begin
                rd_cyc++;
                if (rd_cyc == rdw + 1) begin
                    checkOutput("rd_addr", 32'(ram_addr), 32'(a_old[14:0]));
                    ram_rvalid = 1'b1;
                    ram_rdata  = mem[a_old[14:0]];
                end
            end
            if (ram_wr) begin
                wr_cyc++;
                if (wr_cyc == wrw + 1) begin
                    last_wr_addr = ram_addr;
                    last_wr_data = ram_wdata;
                    checkOutput("wr_addr", 32'(ram_addr), 32'(a_old[14:0]));
                    checkOutput("wr_data", 32'(ram_wdata), 32'(v));
                    ram_wack = 1'b1;
                end
            end
            if (!rom_req && !ram_rd && !ram_wr && !instr_done) begin
                quiet++;
                if (is_c && quiet == 2) begin
                    last_alu_y   = alu_y;
                    last_alu_ctl = alu_ctl;
                    checkOutput("alu_ctl", 32'(alu_ctl), 32'(instr[11:6]));
                    checkOutput("alu_x", 32'(alu_x), 32'(d_old));
                    checkOutput("alu_y", 32'(alu_y), 32'(y_val));
                end
            end
            if (instr_done) done = 1;
        end
        if (!done) checkOutput("timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rom_valid  = 1'b0;
        ram_rvalid = 1'b0;
        ram_wack   = 1'b0;
        if (!is_c) begin
            m_a  = {1'b0, instr[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            if (wr_m) mem[a_old[14:0]] = v;
            m_pc = take ? a_old[14:0] : m_pc + 15'd1;
            if (instr[5]) m_a = v;
            if (instr[4]) m_d = v;
        end
        last_lat    = cyc;
        last_rd_cyc = rd_cyc;
        last_wr_cyc = wr_cyc;
        checkOutput("pc", 32'(pc), 32'(m_pc));
        checkOutput("a", 32'(a_reg), 32'(m_a));
        checkOutput("d", 32'(d_reg), 32'(m_d));
        checkOutput("latency", 32'(cyc), 32'(exp_lat));
        checkOutput("rd_cycles", 32'(rd_cyc), 32'(use_m ? rdw + 1 : 0));
        checkOutput("wr_cycles", 32'(wr_cyc), 32'(wr_m ? wrw + 1 : 0));
    endtask

    initial begin
        rst_n      = 1'b0;
        rom_valid  = 1'b0;
        rom_data   = '0;
        ram_rvalid = 1'b0;
        ram_rdata  = '0;
        ram_wack   = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        $display("[TB] start");

        applyReset();

        // A-instruction with zero-wait ROM: 2-cycle latency.
        applyStimulus(16'h0005, 0, 0, 0);
        checkOutput("dir_a5", 32'(a_reg), 32'd5);
        checkOutput("dir_pc1", 32'(pc), 32'd1);
        checkOutput("dir_lat2", 32'(last_lat), 32'd2);

        // D=A: no memory traffic.
        applyStimulus(16'hEC10, 0, 0, 0);
        checkOutput("dir_ctl_dA", 32'(last_alu_ctl), 32'(6'b110000));
        checkOutput("dir_y5", 32'(last_alu_y), 32'd5);
        checkOutput("dir_d5", 32'(d_reg), 32'd5);
        checkOutput("dir_pc2", 32'(pc), 32'd2);
        checkOutput("dir_no_rd", 32'(last_rd_cyc), 32'd0);
        checkOutput("dir_no_wr", 32'(last_wr_cyc), 32'd0);
        checkOutput("dir_lat4", 32'(last_lat), 32'd4);

        // M=D+1 with the write ack delayed by 3 cycles.
        applyStimulus(16'd100, 0, 0, 0);
        applyStimulus(16'hE7C8, 0, 0, 3);
        checkOutput("dir_wr_hold", 32'(last_wr_cyc), 32'd4);
        checkOutput("dir_wr_addr", 32'(last_wr_addr), 32'd100);
        checkOutput("dir_wr_data", 32'(last_wr_data), 32'd6);
        checkOutput("dir_d_kept", 32'(d_reg), 32'd5);

        // D=D+M with read data arriving after 2 wait cycles.
        applyStimulus(16'd6, 0, 0, 0);
        applyStimulus(16'hEC10, 0, 0, 0);
        mem[7] = 16'd7;
        applyStimulus(16'd7, 0, 0, 0);
        applyStimulus(16'hF090, 0, 2, 0);
        checkOutput("dir_y7", 32'(last_alu_y), 32'd7);
        checkOutput("dir_rd_hold", 32'(last_rd_cyc), 32'd3);
        checkOutput("dir_d13", 32'(d_reg), 32'd13);

        // D;JGT taken, then not taken with D=0, then A=A+1;JMP.
        applyStimulus(16'd42, 0, 0, 0);
        applyStimulus(16'hE301, 0, 0, 0);
        checkOutput("dir_jgt_taken", 32'(pc), 32'd42);
        applyStimulus(16'd0, 0, 0, 0);
        applyStimulus(16'hEC10, 0, 0, 0);
        applyStimulus(16'd42, 0, 0, 0);
        applyStimulus(16'hE301, 0, 0, 0);
        checkOutput("dir_jgt_not", 32'(pc), 32'd46);
        applyStimulus(16'd42, 0, 0, 0);
        applyStimulus(16'hEDE7, 0, 0, 0);
        checkOutput("dir_jmp_a", 32'(a_reg), 32'd43);
        checkOutput("dir_jmp_pc", 32'(pc), 32'd42);

        // PC wraps from 0x7FFF to 0.
        applyStimulus(16'h7FFF, 0, 0, 0);
        applyStimulus(16'hEA87, 0, 0, 0);
        checkOutput("dir_pc_top", 32'(pc), 32'h7FFF);
        applyStimulus(16'h0001, 1, 0, 0);
        checkOutput("dir_pc_wrap", 32'(pc), 32'd0);

        // Reset while a RAM read is outstanding; the late response is ignored.
        applyStimulus(16'd7, 0, 0, 0);
        @(negedge clk);
        rom_valid = 1'b1;
        rom_data  = 16'hF090;
        @(negedge clk);
        rom_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_rd_before", 32'(ram_rd), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mid_rd_after", 32'(ram_rd), 32'd0);
        checkOutput("mid_pc", 32'(pc), 32'd0);
        checkOutput("mid_a", 32'(a_reg), 32'd0);
        checkOutput("mid_d", 32'(d_reg), 32'd0);
        checkOutput("mid_fetch", 32'(rom_req), 32'd1);
        @(negedge clk);
        ram_rvalid = 1'b1;
        ram_rdata  = 16'h1234;
        @(posedge clk);
        #1;
        ram_rvalid = 1'b0;
        checkOutput("mid_late_req", 32'(rom_req), 32'd1);
        checkOutput("mid_late_rd", 32'(ram_rd), 32'd0);
        checkOutput("mid_late_addr", 32'(rom_addr), 32'd0);
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        applyStimulus(16'h0003, 0, 0, 0);
        checkOutput("mid_next_a", 32'(a_reg), 32'd3);
        checkOutput("mid_next_pc", 32'(pc), 32'd1);

        // Randomized instruction stream with random wait states.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            if ($urandom_range(0, 9) < 4)
                ins = {1'b0, 15'($urandom)};
            else
                ins = {3'b111, 1'($urandom), codes[$urandom_range(0, 17)],
                       3'($urandom), 3'($urandom)};
            applyStimulus(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
